game_scan_gen: RTL

Raster scan generator at the display end of the game pipeline. It turns the system clock into a pixel-rate enable, walks horizontal and vertical counters over a full frame, and drives `display_on`, `x` and `y` to the game logic. It also takes back the game's per-pixel colour and emits it to the monitor with `hsync` and `vsync`, blanked outside the visible area. Default timing is 640x480 at 60 Hz from a 50 MHz clock.

---
 rtl/game_scan_gen_if.sv | 31 +++
 rtl/game_scan_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/game_scan_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_scan_gen_if : scan-generator <-> game logic / monitor signal bundle  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface game_scan_gen_if #(
  parameter int GAME_RGB_WIDTH = 12,
  parameter int W_X            = 10,
  parameter int W_Y            = 9
);
  logic [GAME_RGB_WIDTH-1:0] game_rgb;
  logic                      pixel_tick;
  logic                      frame_start;
  logic                      display_on;
  logic [W_X-1:0]            x;
  logic [W_Y-1:0]            y;
  logic                      hsync;
  logic                      vsync;
  logic [GAME_RGB_WIDTH-1:0] vga_rgb;

  modport master (
    input  game_rgb,
    output pixel_tick, frame_start, display_on, x, y, hsync, vsync, vga_rgb
  );

  modport slave (
    output game_rgb,
    input  pixel_tick, frame_start, display_on, x, y, hsync, vsync, vga_rgb
  );
endinterface
`default_nettype wire

// File: rtl/game_scan_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_scan_gen : raster scan generator (pixel enable, h/v counters, sync) |
// | Option macro GAME_SCAN_OUT_REG_EN registers vga_rgb/hsync/vsync.         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module game_scan_gen #(
  parameter int CLK_MHZ         = 50,
  parameter int PIXEL_MHZ       = 25,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int GAME_RGB_WIDTH  = 12,
  parameter int W_X             = $clog2(SCREEN_WIDTH),
  parameter int W_Y             = $clog2(SCREEN_HEIGHT)
) (
  input  logic            clk,
  input  logic            rst,
  game_scan_gen_if.master bus
);

  localparam int c_ratio   = CLK_MHZ / PIXEL_MHZ;
  localparam int c_h_total = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int c_w_h     = $clog2(c_h_total);
  localparam int c_w_v     = $clog2(c_v_total);

  localparam logic [c_w_h-1:0] c_h_last   = c_w_h'(c_h_total - 1);
  localparam logic [c_w_h-1:0] c_h_vis    = c_w_h'(SCREEN_WIDTH);
  localparam logic [c_w_h-1:0] c_hs_start = c_w_h'(SCREEN_WIDTH + H_FRONT);
  localparam logic [c_w_h-1:0] c_hs_end   = c_w_h'(SCREEN_WIDTH + H_FRONT + H_SYNC - 1);
  localparam logic [c_w_v-1:0] c_v_last   = c_w_v'(c_v_total - 1);
  localparam logic [c_w_v-1:0] c_v_vis    = c_w_v'(SCREEN_HEIGHT);
  localparam logic [c_w_v-1:0] c_vs_start = c_w_v'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [c_w_v-1:0] c_vs_end   = c_w_v'(SCREEN_HEIGHT + V_FRONT + V_SYNC - 1);
  localparam logic             c_sync_inv = (SYNC_ACTIVE_LOW != 0);

  logic             w_tick;
  logic [c_w_h-1:0] r_h_cnt;
  logic [c_w_v-1:0] r_v_cnt;
  logic             w_display_on;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_hsync;
  logic             w_vsync;
  logic [GAME_RGB_WIDTH-1:0] w_rgb;

  generate
    if (c_ratio > 1) begin : g_div
      localparam int c_w_div = $clog2(c_ratio);
      localparam logic [c_w_div-1:0] c_div_last = c_w_div'(c_ratio - 1);
      logic [c_w_div-1:0] r_div;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_div <= '0;
        end else if (r_div == c_div_last) begin
          r_div <= '0;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      assign w_tick = (r_div == c_div_last);
    end else begin : g_no_div
      // Pixel rate equals clock rate: every cycle is a pixel.
      assign w_tick = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_tick) begin
      if (r_h_cnt == c_h_last) begin
        r_h_cnt <= '0;
        if (r_v_cnt == c_v_last) begin
          r_v_cnt <= '0;
        end else begin
          r_v_cnt <= r_v_cnt + 1'b1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  assign w_display_on = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
  assign w_hs_act     = (r_h_cnt >= c_hs_start) && (r_h_cnt <= c_hs_end);
  assign w_vs_act     = (r_v_cnt >= c_vs_start) && (r_v_cnt <= c_vs_end);
  assign w_hsync      = w_hs_act ^ c_sync_inv;
  assign w_vsync      = w_vs_act ^ c_sync_inv;
  assign w_rgb        = w_display_on ? bus.game_rgb : '0;

  assign bus.pixel_tick  = w_tick;
  assign bus.frame_start = w_tick && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign bus.display_on  = w_display_on;
  assign bus.x           = w_display_on ? W_X'(r_h_cnt) : '0;
  assign bus.y           = w_display_on ? W_Y'(r_v_cnt) : '0;

`ifdef GAME_SCAN_OUT_REG_EN
  logic                      r_hsync;
  logic                      r_vsync;
  logic [GAME_RGB_WIDTH-1:0] r_vga_rgb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hsync   <= c_sync_inv;
      r_vsync   <= c_sync_inv;
      r_vga_rgb <= '0;
    end else if (w_tick) begin
      r_hsync   <= w_hsync;
      r_vsync   <= w_vsync;
      r_vga_rgb <= w_rgb;
    end
  end

  assign bus.hsync   = r_hsync;
  assign bus.vsync   = r_vsync;
  assign bus.vga_rgb = r_vga_rgb;
`else
  assign bus.hsync   = w_hsync;
  assign bus.vsync   = w_vsync;
  // (0,0) is visible, so colour must be held off explicitly while in reset.
  assign bus.vga_rgb = rst ? w_rgb : '0;
`endif

endmodule
`default_nettype wire
